// File: rtl/lte_time_delay_mc_if.sv
// rtl/lte_time_delay_mc_if.sv - sample stream, delay control and status bundle for lte_time_delay_mc
//
// Purpose: groups the per-channel sample/strobe stream, the delay-update
// controls and the delayed outputs into one bundle.
// Signals (seen from the delay line, slave modport):
//   i_data     in   NCH*DW     channel c at [c*DW +: DW]
//   i_fram_hd  in   NCH        frame-header strobe, travels with the data
//   i_x8hd     in   NCH        x8 header strobe, travels with the data
//   i_upd_hd   in   1          delay-update strobe
//   i_dly_set  in   NCH*DLY_W  delay request for channel c at [c*DLY_W +: DLY_W]
//   i_err_clr  in   1          clears o_dly_err
//   o_data     out  NCH*DW     delayed data, 0 while not valid
//   o_fram_hd  out  NCH        delayed frame-header strobe
//   o_x8hd     out  NCH        delayed x8 strobe
//   o_valid    out  NCH        per-channel output valid
//   o_dly_err  out  NCH        sticky out-of-range delay flag
interface lte_time_delay_mc_if #(
  parameter int DW    = 34,
  parameter int NCH   = 4,
  parameter int DLY_W = 24
);
  logic [NCH*DW-1:0]    i_data;
  logic [NCH-1:0]       i_fram_hd;
  logic [NCH-1:0]       i_x8hd;
  logic                 i_upd_hd;
  logic [NCH*DLY_W-1:0] i_dly_set;
  logic                 i_err_clr;
  logic [NCH*DW-1:0]    o_data;
  logic [NCH-1:0]       o_fram_hd;
  logic [NCH-1:0]       o_x8hd;
  logic [NCH-1:0]       o_valid;
  logic [NCH-1:0]       o_dly_err;

  modport master (
    output i_data, i_fram_hd, i_x8hd, i_upd_hd, i_dly_set, i_err_clr,
    input  o_data, o_fram_hd, o_x8hd, o_valid, o_dly_err
  );

  modport slave (
    input  i_data, i_fram_hd, i_x8hd, i_upd_hd, i_dly_set, i_err_clr,
    output o_data, o_fram_hd, o_x8hd, o_valid, o_dly_err
  );
endinterface

// File: rtl/lte_time_delay_mc.sv
// rtl/lte_time_delay_mc.sv - multi-channel programmable time-delay line with per-channel circular RAM
//
// Purpose: delays each of NCH sample lanes (data + frame/x8 strobes) by a
// per-channel delay D_act committed on i_upd_hd. Fixed pipeline latency of 4:
// input register, RAM write/address, RAM read register, output register.
// Ports:
//   clk        in   datapath clock
//   asy_rst_n  in   asynchronous active-low reset
//   io_bus     slave modport of lte_time_delay_mc_if (stream in, delayed stream out,
//              delay update controls, valid and sticky error flags)
module lte_time_delay_mc #(
  parameter int DW    = 34,
  parameter int NCH   = 4,
  parameter int DEPTH = 6144,
  parameter int AW    = 13,
  parameter int DLY_W = 24
) (
  input  logic                clk,
  input  logic                asy_rst_n,
  lte_time_delay_mc_if.slave  io_bus
);

  localparam int EW = DW + 2;
  localparam int FW = AW + 1;
  localparam logic [AW-1:0]    LAST    = AW'(DEPTH - 1);
  localparam logic [FW-1:0]    FULL    = FW'(DEPTH);
  localparam logic [DLY_W-1:0] DLY_MAX = DLY_W'(DEPTH - 1);

  // r_run goes high on the first edge after reset; r_in_vld lags it by one so the
  // sample captured on that first edge (driven while still in reset) is not counted.
  logic            r_run;
  logic            r_in_vld;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_waddr;

  logic [EW-1:0]   r_in     [NCH];
  logic [EW-1:0]   r_wdata  [NCH];
  logic [EW-1:0]   r_byp    [NCH];
  logic [EW-1:0]   r_ram_q  [NCH];
  logic [AW-1:0]   r_dact   [NCH];
  logic [AW-1:0]   r_raddr  [NCH];
  logic [FW-1:0]   r_fill   [NCH];
  logic [DW-1:0]   r_o_data [NCH];
  logic [NCH-1:0]  r_rd_ok;
  logic [NCH-1:0]  r_rd_vld;
  logic [NCH-1:0]  r_fwd;
  logic [NCH-1:0]  r_fwd_q;
  logic [NCH-1:0]  r_dly_err;
  logic [NCH-1:0]  r_o_fram;
  logic [NCH-1:0]  r_o_x8;
  logic [NCH-1:0]  r_o_valid;

  logic [EW-1:0]   r_ram [NCH][DEPTH];

  logic [DLY_W-1:0] w_req     [NCH];
  logic [NCH-1:0]   w_req_bad;
  logic [AW-1:0]    w_req_cl  [NCH];
  logic [FW-1:0]    w_fill_nxt[NCH];
  logic [AW-1:0]    w_raddr   [NCH];
  logic [EW-1:0]    w_rd      [NCH];

  always_comb begin
    w_req_bad = '0;
    for (int c = 0; c < NCH; c++) begin
      w_req[c]     = io_bus.i_dly_set[c*DLY_W +: DLY_W];
      w_req_bad[c] = (w_req[c] > DLY_MAX);
      w_req_cl[c]  = w_req_bad[c] ? LAST : w_req[c][AW-1:0];
      if (r_fill[c] == FULL) begin
        w_fill_nxt[c] = FULL;
      end else begin
        w_fill_nxt[c] = r_fill[c] + FW'(r_in_vld);
      end
      // Modulo-DEPTH subtraction without a divider; DEPTH need not be 2^AW.
      if (r_wptr >= r_dact[c]) begin
        w_raddr[c] = r_wptr - r_dact[c];
      end else begin
        w_raddr[c] = AW'({1'b0, r_wptr} + FULL - {1'b0, r_dact[c]});
      end
      // With zero delay the RAM read sees the pre-write contents, so bypass.
      w_rd[c] = r_fwd_q[c] ? r_byp[c] : r_ram_q[c];
    end
  end

  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      r_run     <= 1'b0;
      r_in_vld  <= 1'b0;
      r_wptr    <= '0;
      r_waddr   <= '0;
      r_rd_ok   <= '0;
      r_rd_vld  <= '0;
      r_fwd     <= '0;
      r_fwd_q   <= '0;
      r_dly_err <= '0;
      r_o_fram  <= '0;
      r_o_x8    <= '0;
      r_o_valid <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_in[c]     <= '0;
        r_wdata[c]  <= '0;
        r_byp[c]    <= '0;
        r_dact[c]   <= '0;
        r_raddr[c]  <= '0;
        r_fill[c]   <= '0;
        r_o_data[c] <= '0;
      end
    end else begin
      r_run    <= 1'b1;
      r_in_vld <= r_run;
      r_wptr   <= (r_wptr == LAST) ? '0 : r_wptr + AW'(1);
      r_waddr  <= r_wptr;
      r_rd_vld <= r_rd_ok;
      r_fwd_q  <= r_fwd;
      for (int c = 0; c < NCH; c++) begin
        r_in[c]    <= {io_bus.i_fram_hd[c], io_bus.i_x8hd[c], io_bus.i_data[c*DW +: DW]};
        r_wdata[c] <= r_in[c];
        r_byp[c]   <= r_wdata[c];
        r_raddr[c] <= w_raddr[c];
        r_fwd[c]   <= (r_dact[c] == '0);
        r_fill[c]  <= w_fill_nxt[c];
        // Valid means the entry being addressed has been written since reset.
        r_rd_ok[c] <= (w_fill_nxt[c] > {1'b0, r_dact[c]});
        if (io_bus.i_upd_hd) begin
          r_dact[c] <= w_req_cl[c];
        end
        // A new error takes priority over a simultaneous clear.
        if (io_bus.i_upd_hd && w_req_bad[c]) begin
          r_dly_err[c] <= 1'b1;
        end else if (io_bus.i_err_clr) begin
          r_dly_err[c] <= 1'b0;
        end
        r_o_data[c]  <= r_rd_vld[c] ? w_rd[c][DW-1:0] : '0;
        r_o_fram[c]  <= r_rd_vld[c] & w_rd[c][DW+1];
        r_o_x8[c]    <= r_rd_vld[c] & w_rd[c][DW];
        r_o_valid[c] <= r_rd_vld[c];
      end
    end
  end

  // RAM array has no reset; stale contents after reset are masked by valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      r_ram[c][r_waddr] <= r_wdata[c];
      r_ram_q[c]        <= r_ram[c][r_raddr[c]];
    end
  end

  always_comb begin
    io_bus.o_data = '0;
    for (int c = 0; c < NCH; c++) begin
      io_bus.o_data[c*DW +: DW] = r_o_data[c];
    end
  end

  assign io_bus.o_fram_hd = r_o_fram;
  assign io_bus.o_x8hd    = r_o_x8;
  assign io_bus.o_valid   = r_o_valid;
  assign io_bus.o_dly_err = r_dly_err;

endmodule

// File: tb/tb_lte_time_delay_mc.sv
// tb/tb_lte_time_delay_mc.sv - directed self-checking bench for lte_time_delay_mc
module tb_lte_time_delay_mc;
  localparam int DW    = 34;
  localparam int NCH   = 2;
  localparam int DEPTH = 6000;
  localparam int AW    = 13;
  localparam int DLY_W = 24;

  logic clk = 1'b0;
  logic asy_rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int epoch    = 0;
  int fram_at  = -1;
  int x8_at    = -1;
  int bad      = 0;

  lte_time_delay_mc_if #(.DW(DW), .NCH(NCH), .DLY_W(DLY_W)) bus ();

  lte_time_delay_mc #(
    .DW(DW), .NCH(NCH), .DEPTH(DEPTH), .AW(AW), .DLY_W(DLY_W)
  ) dut (
    .clk       (clk),
    .asy_rst_n (asy_rst_n),
    .io_bus    (bus)
  );

  function automatic logic [DW-1:0] ramp0(int k);
    return DW'(k + epoch * 1000000);
  endfunction

  function automatic logic [DW-1:0] ramp1(int k);
    logic [DW-1:0] v;
    v = ramp0(k);
    v[DW-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] od(int c);
    return bus.o_data[c*DW +: DW];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.i_data    = {ramp1(n), ramp0(n)};
    bus.i_fram_hd = (n == fram_at) ? 2'b11 : 2'b00;
    bus.i_x8hd    = (n == x8_at)   ? 2'b11 : 2'b00;
    bus.i_upd_hd  = 1'b0;
    bus.i_err_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n = n + 1;
    drive();
  endtask

  task automatic run_to(int t);
    while (n < t) tick();
  endtask

  task automatic set_dly(int d1, int d0);
    bus.i_dly_set = {DLY_W'(d1), DLY_W'(d0)};
    bus.i_upd_hd  = 1'b1;
  endtask

  initial begin
    asy_rst_n     = 1'b1;
    bus.i_data    = '0;
    bus.i_fram_hd = '0;
    bus.i_x8hd    = '0;
    bus.i_upd_hd  = 1'b0;
    bus.i_dly_set = '0;
    bus.i_err_clr = 1'b0;
    #2 asy_rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.o_valid, 2'b00);
    chk("rst_data", bus.o_data, '0);
    chk("rst_err", bus.o_dly_err, 2'b00);

    @(posedge clk);
    @(posedge clk);
    #3 asy_rst_n = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    fram_at = 10;
    x8_at   = 17;
    drive();
    set_dly(0, 100);

    run_to(3);
    chk("valid_t3", bus.o_valid, 2'b00);
    run_to(4);
    chk("valid_t4", bus.o_valid, 2'b10);
    chk("ch1_d0_t4", od(1), ramp1(0));
    run_to(14);
    chk("fram_ch1", bus.o_fram_hd, 2'b10);
    run_to(21);
    chk("x8_ch1", bus.o_x8hd, 2'b10);
    run_to(103);
    chk("valid_t103", bus.o_valid, 2'b10);
    chk("ch0_mask_t103", od(0), '0);
    run_to(104);
    chk("valid_t104", bus.o_valid, 2'b11);
    chk("ch0_d100_t104", od(0), ramp0(0));
    run_to(113);
    chk("fram_pre", bus.o_fram_hd, 2'b00);
    run_to(114);
    chk("fram_ch0", bus.o_fram_hd, 2'b01);
    chk("fram_ch0_data", od(0), ramp0(10));
    run_to(115);
    chk("fram_post", bus.o_fram_hd, 2'b00);
    run_to(121);
    chk("x8_ch0", bus.o_x8hd, 2'b01);
    chk("x8_ch0_data", od(0), ramp0(17));
    run_to(150);
    chk("ch0_t150", od(0), ramp0(46));
    chk("ch1_t150", od(1), ramp1(146));
    fram_at = -1;
    x8_at   = -1;

    run_to(200);
    set_dly(0, 40);
    run_to(203);
    chk("ch0_old_dly", od(0), ramp0(99));
    run_to(204);
    chk("ch0_skip60", od(0), ramp0(160));
    chk("valid_after_lower", bus.o_valid, 2'b11);

    run_to(300);
    set_dly(0, DEPTH - 1);
    run_to(301);
    chk("err_max_ok", bus.o_dly_err, 2'b00);
    run_to(303);
    chk("ch0_d40_t303", od(0), ramp0(259));
    run_to(304);
    chk("valid_drop_raise", bus.o_valid, 2'b10);
    run_to(6002);
    chk("valid_t6002", bus.o_valid, 2'b10);
    run_to(6003);
    chk("valid_t6003", bus.o_valid, 2'b11);
    chk("ch0_dmax_t6003", od(0), ramp0(0));

    bad = 0;
    while (n < 18100) begin
      tick();
      if (od(0) !== ramp0(n - (DEPTH + 3)) || od(1) !== ramp1(n - 4) || bus.o_valid !== 2'b11)
        bad++;
    end
    chk("wrap_continuity_errs", 64'(bad), 64'd0);

    run_to(18200);
    set_dly(0, DEPTH);
    chk("err_before", bus.o_dly_err, 2'b00);
    run_to(18201);
    chk("err_set", bus.o_dly_err, 2'b01);
    run_to(18206);
    chk("err_sticky", bus.o_dly_err, 2'b01);
    bus.i_err_clr = 1'b1;
    run_to(18207);
    chk("err_cleared", bus.o_dly_err, 2'b00);
    run_to(18210);
    chk("ch0_clamped", od(0), ramp0(18210 - (DEPTH + 3)));
    set_dly(0, DEPTH);
    bus.i_err_clr = 1'b1;
    run_to(18211);
    chk("err_set_wins", bus.o_dly_err, 2'b01);

    run_to(18300);
    set_dly(0, 40);
    run_to(18301);
    chk("err_held", bus.o_dly_err, 2'b01);
    run_to(18303);
    chk("ch0_pre_lower", od(0), ramp0(18303 - (DEPTH + 3)));
    run_to(18304);
    chk("ch0_lowered", od(0), ramp0(18260));
    chk("valid_lowered", bus.o_valid, 2'b11);
    run_to(18400);
    set_dly(0, 200);
    run_to(18403);
    chk("ch0_d40_t18403", od(0), ramp0(18359));
    run_to(18404);
    chk("ch0_raised", od(0), ramp0(18200));
    chk("valid_raised_full", bus.o_valid, 2'b11);

    run_to(18500);
    #1 asy_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.o_valid, 2'b00);
    chk("mid_rst_data", bus.o_data, '0);
    chk("mid_rst_err", bus.o_dly_err, 2'b00);
    chk("mid_rst_strobes", {bus.o_fram_hd, bus.o_x8hd}, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #3 asy_rst_n = 1'b1;
    epoch = 1;
    @(posedge clk);
    #1;
    n = 0;
    drive();
    run_to(3);
    chk("post_rst_valid_t3", bus.o_valid, 2'b00);
    run_to(4);
    chk("post_rst_valid_t4", bus.o_valid, 2'b11);
    chk("post_rst_ch0", od(0), ramp0(0));
    chk("post_rst_ch1", od(1), ramp1(0));
    run_to(10);
    chk("post_rst_ch0_t10", od(0), ramp0(6));
    chk("post_rst_err", bus.o_dly_err, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
